lcd_driver: RTL and testbench
=============================

# lcd_driver

HD44780-style character-LCD driver downstream of the load/store unit's LCD output register (the 32-bit `o_io_lcd` word). Software writes a command/data word with a GO bit; this block detects the GO rising edge and sequences RS/DATA/EN with the required setup, pulse, hold and execution-wait timing. It reports busy, done and overrun status for readback through the input buffer.

## Interface
Parameters:
- `SETUP_CYC`, default 4: cycles RS/DATA are stable before EN rises.
- `EN_CYC`, default 12: cycles EN is held high.
- `HOLD_CYC`, default 4: cycles RS/DATA are held after EN falls.
- `EXEC_CYC`, default 2000: execution wait for normal commands and data (37 µs at 50 MHz, with margin).
- `LONG_EXEC_CYC`, default 80000: execution wait for clear/home (1.52 ms, with margin).
- `POR_CYC`, default 750000: power-on wait after reset (15 ms).

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset; asynchronous and active-high.
- `i_lcd_reg`  in  32  LCD register word.
  - bit 31: ON
  - bit 10: GO
  - bit 8: RS
  - bits 7:0: DATA
- `o_lcd_on`  out  1  display power/backlight.
- `o_lcd_rs`  out  1  register select.
- `o_lcd_rw`  out  1  read/write; tied 0 (write-only).
- `o_lcd_en`  out  1  enable strobe.
- `o_lcd_data`  out  8  data bus.
- `o_busy`  out  1  transfer or power-on wait in progress.
- `o_done`  out  1  one-cycle pulse at end of each transfer.
- `o_err`  out  1  sticky overrun flag.

## Operation
- Timing counter width is `$clog2` of the largest cycle parameter. The counter counts down and loads `<param>-1` on state entry; the state exits when the counter equals 0.
- States: POR_WAIT → IDLE → SETUP → PULSE → HOLD → EXEC → IDLE.
- **POR_WAIT:** entered on reset; lasts POR_CYC cycles; `o_busy`=1.
- **Trigger:** `go_q` registers bit 10 every cycle, in every state. A trigger is `i_lcd_reg[10] & ~go_q`.
- **Trigger in IDLE:** latch RS and DATA into `o_lcd_rs`/`o_lcd_data`, then go to SETUP.
- **Trigger in any other state:** ignored; sets `o_err`. `o_err` clears only on reset.
- **SETUP:** EN=0 for SETUP_CYC cycles.
- **PULSE:** EN=1 for EN_CYC cycles.
- **HOLD:** EN=0 for HOLD_CYC cycles; RS/DATA unchanged.
- **EXEC:** waits LONG_EXEC_CYC if latched RS=0 and DATA[7:2]==0 and DATA≠0 (clear 0x01, home 0x02/0x03); otherwise waits EXEC_CYC.
- **EXEC exit:** assert `o_done` for one cycle; next state IDLE.
- RS/DATA outputs keep their last latched value in IDLE.
- `o_lcd_on` is registered from bit 31 every cycle in every state, independent of the FSM.
- A GO level held high produces exactly one transfer. A new transfer needs GO to fall and rise again.

## Timing
- Reset values (asynchronous, immediate on `i_rst`):
  - `o_lcd_on`=0, `o_lcd_rs`=0, `o_lcd_rw`=0, `o_lcd_en`=0, `o_lcd_data`=0x00
  - `o_busy`=1, `o_done`=0, `o_err`=0
  - `go_q`=0, state POR_WAIT
- POR_WAIT occupies cycles 1..POR_CYC after reset release; IDLE (`o_busy`=0) from cycle POR_CYC+1.
- Trigger seen at edge N:
  - RS/DATA and `o_busy`=1 valid after edge N.
  - EN rises after edge N+SETUP_CYC.
  - EN falls after edge N+SETUP_CYC+EN_CYC.
  - EXEC starts after edge N+SETUP_CYC+EN_CYC+HOLD_CYC.
  - `o_done`=1 in the last EXEC cycle.
  - `o_busy` falls in the same cycle as the IDLE entry.
- A trigger in the same cycle as EXEC→IDLE is ignored and sets `o_err`. Software must poll `o_busy`.
- `o_lcd_on` latency: 1 cycle.
- Reset mid-transfer: EN drops immediately, the FSM returns to POR_WAIT, and the full POR wait is repeated.

## Structure
- Shared package `lcd_pkg`:
  - state enum `lcd_state_e`
  - bit-position constants `LCD_ON_BIT`=31, `LCD_GO_BIT`=10, `LCD_RS_BIT`=8
  - `LCD_CMD_CLEAR`=8'h01, `LCD_CMD_HOME`=8'h02
- Single module: one FSM plus one down-counter. No sub-module is warranted; edge detect and command decode stay inline.

## Test plan
Bench parameters: SETUP=2, EN=3, HOLD=2, EXEC=10, LONG_EXEC=40, POR=20.
- **Reset/POR:** assert `i_rst`, release → all outputs at reset values; `o_busy`=1 for exactly 20 cycles, then 0.
- **Data write:** `i_lcd_reg`=0x0000_0541 (GO, RS=1, 'A') in IDLE → `o_lcd_data`=0x41, `o_lcd_rs`=1; EN high exactly 3 cycles, starting 2 cycles after trigger; `o_done` pulses 17 cycles after trigger.
- **Clear command:** 0x0000_0401 → long wait; `o_done` 47 cycles after trigger. Command 0x0000_0438 → `o_done` at 17 cycles.
- **Overrun:** second GO rising edge during PULSE → ignored (no second EN pulse); `o_err`=1 and stays 1 after `o_done`.
- **GO held high:** GO held for 100 cycles → exactly one EN pulse.
- **Mid-transfer reset and ON bit:** reset asserted during PULSE → EN=0 immediately, POR repeats. Bit 31 toggling in IDLE → `o_lcd_on` follows one cycle later.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character-LCD driver.
// Holds the FSM state encoding, the bit positions inside the 32-bit LCD register
// word, the command codes that need the long execution wait, and a decode helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPorWait = 3'd0,
        StIdle    = 3'd1,
        StSetup   = 3'd2,
        StPulse   = 3'd3,
        StHold    = 3'd4,
        StExec    = 3'd5
    } lcd_state_e;

    localparam int unsigned LCD_ON_BIT = 31;
    localparam int unsigned LCD_GO_BIT = 10;
    localparam int unsigned LCD_RS_BIT = 8;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear (0x01) and return-home (0x02/0x03) are the only instructions that
    // need the long execution wait; all other commands and data writes are short.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_driver.sv
// HD44780-style character-LCD write sequencer.
// Detects a rising edge of the GO bit in the LCD register word and drives
// RS/DATA/EN with setup, enable-pulse, hold and execution-wait timing. After
// reset a power-on wait is enforced before the first transfer is accepted.
//
// Ports:
//   i_clk, i_rst  clock; asynchronous active-high reset
//   i_lcd_reg     register word: [31] ON, [10] GO, [8] RS, [7:0] DATA
//   o_lcd_on      display power/backlight, registered from bit 31
//   o_lcd_rs      register select (latched at trigger)
//   o_lcd_rw      read/write, always 0 (write-only)
//   o_lcd_en      enable strobe
//   o_lcd_data    data bus (latched at trigger)
//   o_busy        power-on wait or transfer in progress
//   o_done        one-cycle pulse in the last execution-wait cycle
//   o_err         sticky: GO rising edge seen while not idle
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 12,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 80000,
    parameter int unsigned POR_CYC       = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int unsigned MAX_C   = (LONG_EXEC_CYC > POR_CYC) ? LONG_EXEC_CYC : POR_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    // Each state lasts <param> cycles: counter loads <param>-1 on entry, exits at 0.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] POR_LOAD   = CNT_W'(POR_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_q;
    logic             on_q;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;

    logic trigger;
    logic cnt_zero;
    logic unused_reg_bits;

    assign unused_reg_bits = ^{i_lcd_reg[30:11], i_lcd_reg[9]};

    assign trigger  = i_lcd_reg[LCD_GO_BIT] & ~go_q;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        err_d   = err_q;

        if (trigger && (state_q != StIdle)) begin
            err_d = 1'b1;
        end

        case (state_q)
            StPorWait: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StIdle: begin
                if (trigger) begin
                    rs_d    = i_lcd_reg[LCD_RS_BIT];
                    data_d  = i_lcd_reg[7:0];
                    state_d = StSetup;
                    cnt_d   = SETUP_LOAD;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d = StPulse;
                    cnt_d   = EN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StExec;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LONG_LOAD : EXEC_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StExec: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StPorWait;
                cnt_d   = POR_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StPorWait;
            cnt_q   <= POR_LOAD;
            go_q    <= 1'b0;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= i_lcd_reg[LCD_GO_BIT];
            on_q    <= i_lcd_reg[LCD_ON_BIT];
            rs_q    <= rs_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Strobe and status decode straight from state so reset drops EN at once.
    assign o_lcd_en   = (state_q == StPulse);
    assign o_busy     = (state_q != StIdle);
    assign o_done     = (state_q == StExec) && cnt_zero;
    assign o_lcd_on   = on_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_lcd_driver.sv
module tb_lcd_driver;

    localparam int unsigned SETUP = 2;
    localparam int unsigned ENC   = 3;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned EXEC  = 10;
    localparam int unsigned LEXEC = 40;
    localparam int unsigned POR   = 20;

    logic        clk;
    logic        rst;
    logic [31:0] lcd_reg;
    logic        lcd_on, lcd_rs, lcd_rw, lcd_en, busy, done, err;
    logic [7:0]  lcd_data;

    int checks;
    int errors;

    lcd_driver #(
        .SETUP_CYC    (SETUP),
        .EN_CYC       (ENC),
        .HOLD_CYC     (HOLD),
        .EXEC_CYC     (EXEC),
        .LONG_EXEC_CYC(LEXEC),
        .POR_CYC      (POR)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_lcd_reg (lcd_reg),
        .o_lcd_on  (lcd_on),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_en  (lcd_en),
        .o_lcd_data(lcd_data),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts consecutive busy cycles starting with the current one (no comparisons).
    task automatic count_busy(output int n);
        n = busy ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
            if (busy) n++;
        end
    endtask

    // Drives one transfer and measures EN/done timing in edges counted from the
    // trigger edge (k=1). Optional GO drop/re-raise at drop_k/rise_k with word2.
    task automatic run_xfer(input logic [31:0] word, input int min_k, input int drop_k,
                            input int rise_k, input logic [31:0] word2,
                            output int en_first, output int en_len, output int en_pulses,
                            output int done_k, output int done_cnt);
        logic prev_en;
        int   after_done;
        en_first = 0; en_len = 0; en_pulses = 0; done_k = 0; done_cnt = 0;
        prev_en = 1'b0; after_done = 0;
        lcd_reg = word;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (lcd_en) begin
                en_len++;
                if (!prev_en) begin
                    en_pulses++;
                    if (en_first == 0) en_first = k;
                end
            end
            prev_en = lcd_en;
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (k == drop_k) lcd_reg = word & ~32'h0000_0400;
            if (k == rise_k) lcd_reg = word2;
            if (done_k != 0) after_done++;
            if (after_done > 3 && k >= min_k) break;
        end
        lcd_reg = lcd_reg & ~32'h0000_0400;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        lcd_reg = 32'h0;
        rst = 1'b1;
        #1;
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL reset_on got %b want 0", lcd_on); end
        checks++; if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0 || lcd_en !== 1'b0) begin
            errors++; $display("FAIL reset_rs_rw_en got %b%b%b want 000", lcd_rs, lcd_rw, lcd_en); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", lcd_data); end
        checks++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_status busy/done/err got %b%b%b want 100", busy, done, err); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        checks++; if (n != POR) begin errors++; $display("FAIL por_busy_cycles got %0d want %0d", n, POR); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_idle busy got %b want 0", busy); end
    endtask

    task automatic test_on_bit();
        lcd_reg = 32'h8000_0000;
        #1;
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL on_before_edge got %b want 0", lcd_on); end
        @(posedge clk); #1;
        checks++; if (lcd_on !== 1'b1) begin errors++; $display("FAIL on_rise got %b want 1", lcd_on); end
        lcd_reg = 32'h0;
        @(posedge clk); #1;
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL on_fall got %b want 0", lcd_on); end
    endtask

    task automatic test_data_write();
        int ef, el, ep, dk, dc;
        lcd_reg = 32'h0000_0541;
        @(posedge clk); #1;
        checks++; if (lcd_rs !== 1'b1 || lcd_data !== 8'h41 || busy !== 1'b1) begin
            errors++; $display("FAIL data_latch rs/data/busy got %b/%h/%b want 1/41/1", lcd_rs, lcd_data, busy); end
        // Re-run a full transfer from the start for timing measurement.
        lcd_reg = 32'h0;
        wait_idle();
        run_xfer(32'h0000_0541, 0, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (ef != SETUP + 1) begin errors++; $display("FAIL data_en_start got %0d want %0d", ef, SETUP + 1); end
        checks++; if (el != ENC || ep != 1) begin
            errors++; $display("FAIL data_en_width len %0d pulses %0d want %0d 1", el, ep, ENC); end
        checks++; if (dk != 17 || dc != 1) begin
            errors++; $display("FAIL data_done at %0d count %0d want 17 1", dk, dc); end
        checks++; if (busy !== 1'b0 || err !== 1'b0 || lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin
            errors++; $display("FAIL data_after busy/err/data/rs got %b/%b/%h/%b want 0/0/41/1", busy, err, lcd_data, lcd_rs); end
    endtask

    // Waits for the first transfer of test_data_write to finish (bounded).
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int ef, el, ep, dk, dc;
        run_xfer(32'h0000_0401, 0, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (dk != 47) begin errors++; $display("FAIL clear_done got %0d want 47", dk); end
        checks++; if (lcd_rs !== 1'b0 || lcd_data !== 8'h01) begin
            errors++; $display("FAIL clear_latch rs/data got %b/%h want 0/01", lcd_rs, lcd_data); end
        run_xfer(32'h0000_0403, 0, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (dk != 47) begin errors++; $display("FAIL home_done got %0d want 47", dk); end
        run_xfer(32'h0000_0438, 0, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (dk != 17) begin errors++; $display("FAIL func_set_done got %0d want 17", dk); end
        run_xfer(32'h0000_0501, 0, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (dk != 17) begin errors++; $display("FAIL data01_done got %0d want 17", dk); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err got %b want 0", err); end
    endtask

    task automatic test_overrun();
        int ef, el, ep, dk, dc;
        // GO low seen at edge 3, rising edge seen at edge 4 while in PULSE.
        run_xfer(32'h0000_0541, 0, 2, 3, 32'h0000_0542, ef, el, ep, dk, dc);
        checks++; if (ep != 1 || el != ENC) begin
            errors++; $display("FAIL overrun_en pulses %0d len %0d want 1 %0d", ep, el, ENC); end
        checks++; if (dk != 17 || dc != 1) begin
            errors++; $display("FAIL overrun_done at %0d count %0d want 17 1", dk, dc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b want 1", err); end
        checks++; if (lcd_data !== 8'h41) begin errors++; $display("FAIL overrun_data got %h want 41", lcd_data); end
    endtask

    task automatic test_go_held();
        int ef, el, ep, dk, dc;
        run_xfer(32'h0000_0548, 100, 0, 0, 32'h0, ef, el, ep, dk, dc);
        checks++; if (ep != 1 || dc != 1) begin
            errors++; $display("FAIL go_held pulses %0d dones %0d want 1 1", ep, dc); end
        checks++; if (lcd_data !== 8'h48 || err !== 1'b1) begin
            errors++; $display("FAIL go_held_state data/err got %h/%b want 48/1", lcd_data, err); end
    endtask

    task automatic test_mid_reset();
        int n;
        lcd_reg = 32'h0000_0455;
        for (int k = 1; k <= SETUP + 1; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_en got %b want 1", lcd_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (lcd_en !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_async en/busy/err got %b/%b/%b want 0/1/0", lcd_en, busy, err); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", lcd_data); end
        lcd_reg = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        checks++; if (n != POR) begin errors++; $display("FAIL midrst_por got %0d want %0d", n, POR); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        lcd_reg = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_on_bit();
        test_data_write();
        test_clear();
        test_overrun();
        test_go_held();
        test_mid_reset();
        test_on_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
